// File: rtl/hms_pkg.sv
// Shared defaults and encodings for the hh:mm:ss timekeeper.
package hms_pkg;

    localparam int unsigned SEC_MAX_DEF  = 59;
    localparam int unsigned MIN_MAX_DEF  = 59;
    localparam int unsigned HOUR_MAX_DEF = 23;
    localparam int unsigned MS_W_DEF     = 6;
    localparam int unsigned HOUR_W_DEF   = 5;

    localparam logic MODE_CLOCK = 1'b0;
    localparam logic MODE_TIMER = 1'b1;
    localparam logic DIR_DOWN   = 1'b0;
    localparam logic DIR_UP     = 1'b1;

endpackage

// File: rtl/hms_mod_stage.sv
// One modular up/down field with clamped preset and combinational carry/borrow out.
module hms_mod_stage
    import hms_pkg::*;
#(
    parameter int unsigned MAX_VAL = 59,
    parameter int unsigned W       = 6
) (
    input  logic         CLOCK_50_div,
    input  logic         debouncer_rst,
    input  logic         step_in,
    input  logic         up_down,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         carry_out
);

    localparam logic [W-1:0] MAX_V = W'(MAX_VAL);

    assign carry_out = step_in && ((up_down == DIR_UP) ? (value == MAX_V) : (value == '0));

    always_ff @(posedge CLOCK_50_div or posedge debouncer_rst) begin
        if (debouncer_rst) begin
            value <= '0;
        end else if (load) begin
            value <= (load_val > MAX_V) ? MAX_V : load_val;
        end else if (step_in) begin
            if (up_down == DIR_UP)
                value <= (value == MAX_V) ? '0 : value + 1'b1;
            else
                value <= (value == '0) ? MAX_V : value - 1'b1;
        end
    end

endmodule

// File: rtl/hms_timekeeper.sv
// hh:mm:ss up/down timekeeper, clock (wrap) or timer (stop) mode.
// Optional alarm output enabled by defining HMS_TIMEKEEPER_ALARM_EN.
module hms_timekeeper
    import hms_pkg::*;
#(
    parameter int unsigned SEC_MAX  = SEC_MAX_DEF,
    parameter int unsigned MIN_MAX  = MIN_MAX_DEF,
    parameter int unsigned HOUR_MAX = HOUR_MAX_DEF,
    parameter int unsigned MS_W     = MS_W_DEF,
    parameter int unsigned HOUR_W   = HOUR_W_DEF
) (
    input  logic              CLOCK_50_div,
    input  logic              debouncer_rst,
    input  logic              en,
    input  logic              up_down,
    input  logic              mode,
    input  logic              load,
    input  logic [MS_W-1:0]   load_sec,
    input  logic [MS_W-1:0]   load_min,
    input  logic [HOUR_W-1:0] load_hour,
    output logic [MS_W-1:0]   sec,
    output logic [MS_W-1:0]   min,
    output logic [HOUR_W-1:0] hour,
    output logic              rollover,
`ifdef HMS_TIMEKEEPER_ALARM_EN
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MS_W-1:0]   alarm_min,
    output logic              alarm,
`endif
    output logic              done
);

    localparam logic [MS_W-1:0]   SEC_M  = MS_W'(SEC_MAX);
    localparam logic [MS_W-1:0]   SEC_PM = MS_W'(SEC_MAX - 1);
    localparam logic [MS_W-1:0]   MIN_M  = MS_W'(MIN_MAX);
    localparam logic [HOUR_W-1:0] HOUR_M = HOUR_W'(HOUR_MAX);

    logic timer, at_term, land_term, step;
    logic sec_carry, min_carry, hour_carry;

    assign timer = (mode == MODE_TIMER);

    // Terminal now, and "one step away from terminal" so done rises on the landing edge.
    always_comb begin
        if (up_down == DIR_UP) begin
            at_term   = (hour == HOUR_M) && (min == MIN_M) && (sec == SEC_M);
            land_term = (hour == HOUR_M) && (min == MIN_M) && (sec == SEC_PM);
        end else begin
            at_term   = (hour == '0) && (min == '0) && (sec == '0);
            land_term = (hour == '0) && (min == '0) && (sec == MS_W'(1));
        end
    end

    assign step = en && !load && !(timer && (done || at_term));

    hms_mod_stage #(.MAX_VAL(SEC_MAX), .W(MS_W)) u_sec (
        .CLOCK_50_div (CLOCK_50_div),
        .debouncer_rst(debouncer_rst),
        .step_in      (step),
        .up_down      (up_down),
        .load         (load),
        .load_val     (load_sec),
        .value        (sec),
        .carry_out    (sec_carry)
    );

    hms_mod_stage #(.MAX_VAL(MIN_MAX), .W(MS_W)) u_min (
        .CLOCK_50_div (CLOCK_50_div),
        .debouncer_rst(debouncer_rst),
        .step_in      (sec_carry),
        .up_down      (up_down),
        .load         (load),
        .load_val     (load_min),
        .value        (min),
        .carry_out    (min_carry)
    );

    hms_mod_stage #(.MAX_VAL(HOUR_MAX), .W(HOUR_W)) u_hour (
        .CLOCK_50_div (CLOCK_50_div),
        .debouncer_rst(debouncer_rst),
        .step_in      (min_carry),
        .up_down      (up_down),
        .load         (load),
        .load_val     (load_hour),
        .value        (hour),
        .carry_out    (hour_carry)
    );

    always_ff @(posedge CLOCK_50_div or posedge debouncer_rst) begin
        if (debouncer_rst)
            done <= 1'b0;
        else if (load || !timer)
            done <= 1'b0;
        else if (en && !done && (at_term || land_term))
            done <= 1'b1;
    end

    always_ff @(posedge CLOCK_50_div or posedge debouncer_rst) begin
        if (debouncer_rst)
            rollover <= 1'b0;
        else
            rollover <= step && !timer && hour_carry;
    end

`ifdef HMS_TIMEKEEPER_ALARM_EN
    logic stepped_q;

    // Remember that the current value arrived by a step, so loads never fire the alarm.
    always_ff @(posedge CLOCK_50_div or posedge debouncer_rst) begin
        if (debouncer_rst) begin
            stepped_q <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            stepped_q <= step;
            alarm     <= stepped_q && (hour == alarm_hour) && (min == alarm_min) && (sec == '0);
        end
    end
`endif

endmodule
